// File: rtl/flight_eq_pkg.sv
// Shared types and constants for the flight equation engine.
package flight_eq_pkg;

   localparam int unsigned W_IN_DEF  = 8;
   localparam int unsigned W_OUT_DEF = 16;

   // Equation coefficients: A = x1*ALT_K1 + x2*ALT_K2, B = v*t + c*BAT_K2
   localparam int ALT_K1 = 3;
   localparam int ALT_K2 = 5;
   localparam int BAT_K2 = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STEP1 = 2'd1,
      ST_STEP2 = 2'd2
   } state_t;

endpackage

// File: rtl/flight_eq_unit_smul8x8.sv
// Combinational signed W_IN x W_IN multiplier, full-width product.
module smul8x8 #(
   parameter int unsigned W_IN = 8
) (
   input  logic signed [W_IN-1:0]   a,
   input  logic signed [W_IN-1:0]   b,
   output logic signed [2*W_IN-1:0] p
);

   // Operands are sign-extended to the product width before multiplying
   always_comb begin
      p = (2*W_IN)'(a) * (2*W_IN)'(b);
   end

endmodule

// File: rtl/flight_eq_unit.sv
// Sequential altitude/battery equation engine sharing one signed multiplier.
module flight_eq_unit
   import flight_eq_pkg::*;
#(
   parameter int unsigned W_IN  = W_IN_DEF,
   parameter int unsigned W_OUT = W_OUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [W_IN-1:0]  x1,
   input  logic signed [W_IN-1:0]  x2,
   input  logic signed [W_IN-1:0]  v,
   input  logic signed [W_IN-1:0]  t,
   input  logic signed [W_IN-1:0]  c,
   input  logic                    sel_eq,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [W_OUT-1:0] result_a,
   output logic signed [W_OUT-1:0] result_b,
   output logic                    out_valid,
   output logic                    out_sel
);

   state_t                  state_q, state_d;
   logic signed [W_IN-1:0]  x1_q, x2_q, v_q, t_q, c_q;
   logic                    sel_q;
   logic signed [W_OUT-1:0] acc_q;
   logic signed [W_IN-1:0]  mul_a, mul_b;
   logic signed [2*W_IN-1:0] mul_p;
   logic signed [W_OUT-1:0] mul_ext;
   logic                    accept, step1_en, step2_en;

   smul8x8 #(.W_IN(W_IN)) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   assign mul_ext  = W_OUT'(mul_p);
   assign in_ready = (state_q == ST_IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and multiplier operand selection
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      step1_en = 1'b0;
      step2_en = 1'b0;
      mul_a    = sel_q ? v_q : x1_q;
      mul_b    = sel_q ? t_q : W_IN'(ALT_K1);
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ST_STEP1;
            end
         end
         ST_STEP1: begin
            step1_en = 1'b1;
            state_d  = ST_STEP2;
         end
         ST_STEP2: begin
            step2_en = 1'b1;
            mul_a    = sel_q ? c_q : x2_q;
            mul_b    = sel_q ? W_IN'(BAT_K2) : W_IN'(ALT_K2);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture, accumulator, held results and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1_q      <= '0;
         x2_q      <= '0;
         v_q       <= '0;
         t_q       <= '0;
         c_q       <= '0;
         sel_q     <= 1'b0;
         acc_q     <= '0;
         result_a  <= '0;
         result_b  <= '0;
         out_valid <= 1'b0;
         out_sel   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            x1_q  <= x1;
            x2_q  <= x2;
            v_q   <= v;
            t_q   <= t;
            c_q   <= c;
            sel_q <= sel_eq;
         end
         if (step1_en) acc_q <= mul_ext;
         if (step2_en) begin
            if (sel_q) result_b <= acc_q + mul_ext;
            else       result_a <= acc_q + mul_ext;
            out_valid <= 1'b1;
            out_sel   <= sel_q;
         end
      end
   end

endmodule

// File: tb/tb_flight_eq_unit.sv
// Self-checking bench for flight_eq_unit with an arithmetic reference model.
module tb_flight_eq_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  x1, x2, v, t, c;
   logic        sel_eq, in_valid;
   logic        in_ready, out_valid, out_sel;
   logic [15:0] result_a, result_b;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_a   = 16'd0;
   logic [15:0] exp_b   = 16'd0;

   always #5 clk = ~clk;

   flight_eq_unit dut (
      .clk(clk), .rst(rst), .x1(x1), .x2(x2), .v(v), .t(t), .c(c),
      .sel_eq(sel_eq), .in_valid(in_valid), .in_ready(in_ready),
      .result_a(result_a), .result_b(result_b),
      .out_valid(out_valid), .out_sel(out_sel)
   );

   function automatic logic [15:0] model_alt(input logic [7:0] a1, input logic [7:0] a2);
      int r;
      r = int'($signed(a1)) * 3 + int'($signed(a2)) * 5;
      return 16'(r);
   endfunction

   function automatic logic [15:0] model_bat(input logic [7:0] bv, input logic [7:0] bt,
                                             input logic [7:0] bc);
      int r;
      r = int'($signed(bv)) * int'($signed(bt)) + int'($signed(bc));
      return 16'(r);
   endfunction

   // Issue one request and wait (bounded) for out_valid; returns edges after accept
   task automatic run_op(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] bv,
                         input logic [7:0] bt, input logic [7:0] bc, input logic s,
                         output int lat);
      int w = 0;
      while (!in_ready && w < 10) begin
         @(posedge clk); #1; w++;
      end
      x1 = a1; x2 = a2; v = bv; t = bt; c = bc; sel_eq = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!out_valid && lat < 10);
      if (s) exp_b = model_bat(bv, bt, bc);
      else   exp_a = model_alt(a1, a2);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; sel_eq = 1'b0;
      x1 = '0; x2 = '0; v = '0; t = '0; c = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sel !== 1'b0 ||
          result_a !== 16'd0 || result_b !== 16'd0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b ov=%b os=%b a=%h b=%h, required 1 0 0 0000 0000",
                  in_ready, out_valid, out_sel, result_a, result_b);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_altitude();
      int lat;
      run_op(8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0, lat);
      n_tests++;
      if (lat !== 2 || out_valid !== 1'b1 || out_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL alt_handshake: lat=%0d ov=%b os=%b, required 2 1 0", lat, out_valid, out_sel);
      end
      n_tests++;
      if (result_a !== exp_a || result_a !== 16'd29 || result_b !== 16'd0) begin
         n_fail++;
         $display("FAIL alt_value: a=%0d b=%0d, required a=29 b=0", $signed(result_a), $signed(result_b));
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL alt_pulse: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_battery();
      int lat;
      run_op(8'd55, 8'd66, 8'd2, 8'd5, 8'd16, 1'b1, lat);
      n_tests++;
      if (lat !== 2 || out_sel !== 1'b1 || result_b !== exp_b || result_b !== 16'd26 ||
          result_a !== 16'd29) begin
         n_fail++;
         $display("FAIL battery: lat=%0d os=%b a=%0d b=%0d, required 2 1 29 26",
                  lat, out_sel, $signed(result_a), $signed(result_b));
      end
   endtask

   task automatic test_extremes();
      int lat;
      run_op(8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 1'b0, lat);
      n_tests++;
      if (result_a !== exp_a || result_a !== 16'hFC00) begin
         n_fail++;
         $display("FAIL alt_extreme: a=%h, required fc00", result_a);
      end
      run_op(8'd0, 8'd0, 8'h80, 8'h80, 8'h7F, 1'b1, lat);
      n_tests++;
      if (result_b !== exp_b || result_b !== 16'h407F || result_a !== 16'hFC00) begin
         n_fail++;
         $display("FAIL bat_extreme: a=%h b=%h, required fc00 407f", result_a, result_b);
      end
   endtask

   task automatic test_stability();
      x1 = 8'd3; x2 = 8'd4; sel_eq = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stab_ready_s1: rdy=%b, required 0", in_ready);
      end
      x1 = 8'd100; x2 = 8'd77; sel_eq = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stab_ready_s2: rdy=%b ov=%b, required 0 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      exp_a = model_alt(8'd3, 8'd4);
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 1'b0 || result_a !== exp_a || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stability: ov=%b os=%b a=%0d rdy=%b, required 1 0 29 1",
                  out_valid, out_sel, $signed(result_a), in_ready);
      end
   endtask

   // in_valid held high; operands scrambled after each accept must not matter
   task automatic test_continuous();
      logic [7:0] a1, a2, bv, bt, bc;
      logic s;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s = k[0];
         a1 = 8'($urandom_range(0, 255)); a2 = 8'($urandom_range(0, 255));
         bv = 8'($urandom_range(0, 255)); bt = 8'($urandom_range(0, 255));
         bc = 8'($urandom_range(0, 255));
         x1 = a1; x2 = a2; v = bv; t = bt; c = bc; sel_eq = s;
         if (s) exp_b = model_bat(bv, bt, bc);
         else   exp_a = model_alt(a1, a2);
         for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
               x1 = 8'($urandom); x2 = 8'($urandom); v = 8'($urandom);
               t = 8'($urandom); c = 8'($urandom); sel_eq = ~s;
            end
            n_tests++;
            if (out_valid !== (cyc == 3)) begin
               n_fail++;
               $display("FAIL cont_pulse k=%0d cyc=%0d: ov=%b, required %b", k, cyc, out_valid, cyc == 3);
            end
         end
         n_tests++;
         if (out_sel !== s || result_a !== exp_a || result_b !== exp_b) begin
            n_fail++;
            $display("FAIL cont_value k=%0d: os=%b a=%h b=%h, required %b %h %h",
                     k, out_sel, result_a, result_b, s, exp_a, exp_b);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat;
      logic s;
      for (int k = 0; k < 24; k++) begin
         s = 1'($urandom_range(0, 1));
         run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), s, lat);
         n_tests++;
         if (lat !== 2 || out_sel !== s || result_a !== exp_a || result_b !== exp_b) begin
            n_fail++;
            $display("FAIL random k=%0d: lat=%0d os=%b a=%h b=%h, required 2 %b %h %h",
                     k, lat, out_sel, result_a, result_b, s, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      int lat;
      x1 = 8'd10; x2 = 8'd20; sel_eq = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      exp_a = 16'd0; exp_b = 16'd0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sel !== 1'b0 ||
          result_a !== 16'd0 || result_b !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: rdy=%b ov=%b os=%b a=%h b=%h, required 1 0 0 0000 0000",
                  in_ready, out_valid, out_sel, result_a, result_b);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1 || in_ready !== 1'b1) seen = 1'b1;
      end
      in_valid = 1'b0;
      #2 rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1 || in_ready !== 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: spurious out_valid or in_ready low, required none");
      end
      run_op(8'hF6, 8'd7, 8'd0, 8'd0, 8'd0, 1'b0, lat);
      n_tests++;
      if (lat !== 2 || result_a !== exp_a || result_b !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_recover: lat=%0d a=%h b=%h, required 2 %h 0000",
                  lat, result_a, result_b, exp_a);
      end
   endtask

   initial begin
      test_reset();
      test_altitude();
      test_battery();
      test_extremes();
      test_stability();
      test_continuous();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flight_eq_unit.md
# flight_eq_unit

Sequential equation engine that evaluates the altitude equation A = (x1·3) + (x2·5) and the battery equation B = (v·t) + c on signed 8-bit operands. It is the unit under test driven by the built-in self-test sequencer and by the normal sensor path; the top level muxes those sources onto its operand ports. A single shared signed multiplier is time-multiplexed by a small FSM. Each result is held on its own 16-bit output until the next operation of the same kind completes.

## Interface
Parameters:
- W_IN, 8, operand width (signed, two's complement)
- W_OUT, 16, result width (signed)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- x1  in  W_IN  altitude operand 1 (signed)
- x2  in  W_IN  altitude operand 2 (signed)
- v  in  W_IN  battery operand v (signed)
- t  in  W_IN  battery operand t (signed)
- c  in  W_IN  battery offset c (signed)
- sel_eq  in  1  0 = altitude, 1 = battery
- in_valid  in  1  operation request; may be tied high for continuous recompute
- in_ready  out  1  high only in IDLE
- result_a  out  W_OUT  last altitude result (signed), held
- result_b  out  W_OUT  last battery result (signed), held
- out_valid  out  1  one-cycle pulse when a result register updates
- out_sel  out  1  equation of the result signalled by out_valid

## Operation
- FSM states: IDLE, STEP1, STEP2.
- IDLE: in_ready=1. Accept on in_valid && in_ready at a clock edge. At that edge, register all five operands and sel_eq, then go to STEP1.
- STEP1: acc <= mul(opA1, opB1); go to STEP2.
  - Altitude: opA1=x1, opB1=3.
  - Battery: opA1=v, opB1=t.
- STEP2: result <= acc + mul(opA2, opB2); go to IDLE.
  - Altitude: opA2=x2, opB2=5; writes result_a.
  - Battery: opA2=c, opB2=1; writes result_b.
  - At the same edge: out_valid<=1 and out_sel<=registered sel.
- out_valid is cleared on every other edge.
- Arithmetic:
  - The multiplier is signed 8×8 to 16 bits.
  - acc and the sum are 16-bit signed, with all terms sign-extended.
  - Worst cases: -1024 (altitude) and 16511 (battery). No overflow is possible, so no saturation is applied.
- Operand changes after acceptance are ignored until the next accept.
- The result for the equation not selected is untouched.
- Reset values: state=IDLE, in_ready=1, result_a=0, result_b=0, out_valid=0, out_sel=0, acc=0, operand registers=0.
- Reset mid-operation aborts the operation. No out_valid is issued, and results return to 0.
- in_valid is ignored while rst is high.

## Timing
- Accept at edge E0. acc is valid after E1. The result register and out_valid are visible after E2, so latency is 2 edges.
- in_ready is low in STEP1/STEP2, giving a maximum throughput of one operation per 3 cycles.
- With in_valid held high, the unit re-accepts at E3, E6, and so on. out_valid pulses for 1 cycle in every 3.
- Result ports are registered outputs. in_ready is decoded combinationally from state.
- A self-test sequence holding operands stable for 3 or more cycles with in_valid high always sees a correct result before its check window opens.

## Structure
- Package flight_eq_pkg:
  - state encoding (2-bit)
  - ALT_K1=3 and ALT_K2=5
  - BAT_K2=1
  - W_IN/W_OUT defaults
- Sub-module smul8x8: combinational signed W_IN×W_IN multiplier, instantiated once. The operand mux lives in flight_eq_unit.

## Test plan
- Altitude self-test vector: x1=3, x2=4, sel_eq=0, in_valid pulse → out_valid 2 edges later, out_sel=0, result_a=29, result_b unchanged (0).
- Battery self-test vector: v=2, t=5, c=16, sel_eq=1 → result_b=26, out_sel=1; result_a retains its prior value (29).
- Signed extremes:
  - x1=x2=-128 → result_a=0xFC00 (-1024).
  - v=t=-128, c=127 → result_b=0x407F (16511).
- Operand stability: accept x1=3, x2=4, then change x1=100 at E1 → result_a=29, and in_ready=0 during STEP1/STEP2.
- Continuous mode: in_valid tied high while sel_eq toggles every 3 cycles → out_valid pulses every 3rd cycle, with alternating correct results.
- Reset mid-operation: assert rst asynchronously in STEP1 → outputs reach their reset values immediately. No out_valid pulse; in_ready=1 after release.
